// File: rtl/nios_onchip_ram_pipelined.sv
// Single-port on-chip RAM behind an Avalon-MM pipelined slave (read latency 1 or 2, clken stall).
// Optional per-byte even parity (parity_err / parity_inject) when NIOS_ONCHIP_RAM_PARITY_EN is defined.
module nios_onchip_ram_pipelined #(
    parameter int    DATA_WIDTH   = 16,
    parameter int    ADDR_WIDTH   = 13,
    parameter int    DEPTH        = 8192,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "nios_system_onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    range_err
`ifdef NIOS_ONCHIP_RAM_PARITY_EN
    ,
    output logic                    parity_err,
    input  logic                    parity_inject
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = AW1'(DEPTH);

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_data_width
        $error("nios_onchip_ram_pipelined: DATA_WIDTH must be a multiple of 8 in 8..128");
    end
    if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("nios_onchip_ram_pipelined: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("nios_onchip_ram_pipelined: READ_LATENCY must be 1 or 2");
    end

    // Contents are preloaded by the FPGA tools from INIT_FILE at configuration time.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             adv;
    logic             go;
    logic             wr_acc;
    logic             rd_acc;
    logic             in_range;
    logic [IDX_W-1:0] addr_idx;

    // Reset has priority over the stall: nothing is accepted or advanced in a reset cycle.
    assign adv      = clken & ~reset_req;
    assign go       = adv & ~reset;
    assign wr_acc   = go & chipselect & write;
    assign rd_acc   = go & chipselect & read & ~write;
    assign in_range = ({1'b0, address} < DEPTH_LIM);
    assign addr_idx = address[IDX_W-1:0];

    // NOTE: the storage array is deliberately left out of any reset so it maps onto block RAM;
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    mem[addr_idx][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_data;

    // First stage is the RAM output register; data only changes on an accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else if (adv) begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_data <= in_range ? mem[addr_idx] : '0;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_vld;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_vld  <= 1'b0;
                s2_data <= '0;
            end else if (adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign out_vld  = s2_vld;
        assign out_data = s2_data;
    end else begin : g_lat1
        assign out_vld  = s1_vld;
        assign out_data = s1_data;
    end

    // A held valid is only presented in a cycle where the pipeline moves, so it retires exactly once.
    assign readdatavalid = out_vld & adv & ~reset;
    assign readdata      = out_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            range_err <= 1'b0;
        end else if ((wr_acc || rd_acc) && !in_range) begin
            range_err <= 1'b1;
        end
    end

`ifdef NIOS_ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          rd_perr;
    logic          s1_perr;
    logic          out_perr;

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    par_mem[addr_idx][b] <= (^writedata[b*8 +: 8]) ^ parity_inject;
                end
            end
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through this block can infer a latch.
        rd_perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            rd_perr = rd_perr | ((^mem[addr_idx][b*8 +: 8]) ^ par_mem[addr_idx][b]);
        end
        if (!in_range) begin
            rd_perr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_perr <= 1'b0;
        end else if (adv && rd_acc) begin
            s1_perr <= rd_perr;
        end
    end

    if (READ_LATENCY == 2) begin : g_par_lat2
        logic s2_perr;

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_perr <= 1'b0;
            end else if (adv && s1_vld) begin
                s2_perr <= s1_perr;
            end
        end

        assign out_perr = s2_perr;
    end else begin : g_par_lat1
        assign out_perr = s1_perr;
    end

    assign parity_err = out_perr & readdatavalid;
`endif

endmodule

// File: tb/tb_nios_onchip_ram_pipelined.sv
// Scoreboard bench: two RAM instances (latency 1 / depth 8192 and latency 2 / depth 6000)
// share stimulus; a word-level model predicts every read and its due slot in advancing cycles.
module tb_nios_onchip_ram_pipelined;

    localparam int DW = 16;
    localparam int AW = 13;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            due;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          reset_req;
    logic          clken;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [1:0]    byteenable;
    logic [DW-1:0] writedata;
    logic          parity_inject;
    logic [DW-1:0] rdata_o [2];
    logic          rvld_o  [2];
    logic          rerr_o  [2];
`ifdef NIOS_ONCHIP_RAM_PARITY_EN
    logic          perr_o  [2];
`endif

    exp_t          sb       [2][$];
    logic [DW-1:0] mdl      [2][8192];
    logic [1:0]    mpb      [2][8192];
    logic          rerr_mdl [2];
    int            adv_cnt;
    int            mon_cnt;
    int            n_cmp;
    int            n_fail;

    nios_onchip_ram_pipelined #(
        .DATA_WIDTH(16), .ADDR_WIDTH(13), .DEPTH(8192), .READ_LATENCY(1), .INIT_FILE("")
    ) u_lat1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .byteenable(byteenable), .writedata(writedata),
        .readdata(rdata_o[0]), .readdatavalid(rvld_o[0]), .range_err(rerr_o[0])
`ifdef NIOS_ONCHIP_RAM_PARITY_EN
        , .parity_err(perr_o[0]), .parity_inject(parity_inject)
`endif
    );

    nios_onchip_ram_pipelined #(
        .DATA_WIDTH(16), .ADDR_WIDTH(13), .DEPTH(6000), .READ_LATENCY(2), .INIT_FILE("")
    ) u_lat2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .byteenable(byteenable), .writedata(writedata),
        .readdata(rdata_o[1]), .readdatavalid(rvld_o[1]), .range_err(rerr_o[1])
`ifdef NIOS_ONCHIP_RAM_PARITY_EN
        , .parity_err(perr_o[1]), .parity_inject(parity_inject)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 8192 : 6000;
    endfunction

    function automatic int rand_addr();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 63));
            1:       return int'($urandom_range(5990, 6009));
            default: return int'($urandom_range(8180, 8191));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: check sticky flags left by the previous cycle, drive inputs, update the model.
    task automatic cycle(input int rst, input int rreq, input int ce, input int cs,
                         input int r, input int w, input int a, input int be,
                         input int d, input int pi);
        logic [DW-1:0] d16;
        exp_t          e;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("range_err[%0d]", k), 32'(rerr_o[k]), 32'(rerr_mdl[k]));
        end
        d16           = 16'(d);
        reset         = (rst != 0);
        reset_req     = (rreq != 0);
        clken         = (ce != 0);
        chipselect    = (cs != 0);
        read          = (r != 0);
        write         = (w != 0);
        address       = 13'(a);
        byteenable    = 2'(be);
        writedata     = d16;
        parity_inject = (pi != 0);
        if (rst != 0) begin
            for (int k = 0; k < 2; k++) begin
                sb[k].delete();
                rerr_mdl[k] = 1'b0;
            end
            adv_cnt = 0;
        end else if (ce != 0 && rreq == 0) begin
            for (int k = 0; k < 2; k++) begin
                if (cs != 0 && w != 0) begin
                    if (a < depth_of(k)) begin
                        for (int b = 0; b < 2; b++) begin
                            if (be[b]) begin
                                mdl[k][a][b*8 +: 8] = d16[b*8 +: 8];
                                mpb[k][a][b]        = (pi != 0);
                            end
                        end
                    end else begin
                        rerr_mdl[k] = 1'b1;
                    end
                end else if (cs != 0 && r != 0) begin
                    e.data = (a < depth_of(k)) ? mdl[k][a] : '0;
                    e.perr = (a < depth_of(k)) && (mpb[k][a] != 2'b00);
                    e.due  = adv_cnt + lat_of(k);
                    sb[k].push_back(e);
                    if (a >= depth_of(k)) rerr_mdl[k] = 1'b1;
                end
            end
            adv_cnt++;
        end
    endtask

    task automatic wr(input int a, input int d, input int be, input int pi);
        cycle(0, 0, 1, 1, 0, 1, a, be, d, pi);
    endtask

    task automatic rd(input int a);
        cycle(0, 0, 1, 1, 1, 0, a, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the N-th advancing cycle after a read acceptance must carry its data (N = latency).
    initial begin
        exp_t e;
        mon_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) mon_cnt = 0;
            if (!reset && clken && !reset_req) begin
                for (int k = 0; k < 2; k++) begin
                    if (sb[k].size() > 0 && sb[k][0].due == mon_cnt) begin
                        e = sb[k].pop_front();
                        check($sformatf("valid_due[%0d]", k), 32'(rvld_o[k]), 32'd1);
                        if (rvld_o[k]) begin
                            check($sformatf("readdata[%0d]", k), 32'(rdata_o[k]), 32'(e.data));
`ifdef NIOS_ONCHIP_RAM_PARITY_EN
                            check($sformatf("parity_err[%0d]", k), 32'(perr_o[k]), 32'(e.perr));
`endif
                        end
                    end else begin
                        check($sformatf("no_valid[%0d]", k), 32'(rvld_o[k]), 32'd0);
                    end
                end
                mon_cnt++;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("stall_valid[%0d]", k), 32'(rvld_o[k]), 32'd0);
                end
            end
        end
    end

    initial begin
        int op;
        int a;
        n_cmp   = 0;
        n_fail  = 0;
        adv_cnt = 0;
        for (int k = 0; k < 2; k++) rerr_mdl[k] = 1'b0;
        reset = 1'b1; reset_req = 1'b0; clken = 1'b0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; address = '0; byteenable = '0;
        writedata = '0; parity_inject = 1'b0;

        repeat (3) cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_readdata[%0d]", k), 32'(rdata_o[k]), 32'd0);
            check($sformatf("reset_valid[%0d]", k), 32'(rvld_o[k]), 32'd0);
        end

        // Preload every address the bench will touch, then reset to clear the sticky flag.
        for (int i = 0; i < 64; i++)      wr(i, int'($urandom_range(0, 65535)), 3, 0);
        for (int i = 5990; i < 6010; i++) wr(i, int'($urandom_range(0, 65535)), 3, 0);
        for (int i = 8180; i < 8192; i++) wr(i, int'($urandom_range(0, 65535)), 3, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        wr(16'h0010, 16'hA55A, 3, 0);
        rd(16'h0010);
        wr(5, 16'h1234, 3, 0);
        wr(5, 16'hFFFF, 1, 0);
        rd(5);
        for (int i = 0; i < 4; i++) wr(i, 16'h11 * (i + 1), 3, 0);
        rd(0);
        rd(1);
        cycle(0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
        rd(2);
        rd(3);
        idle(3);

        wr(6000, 16'hBEEF, 3, 0);
        rd(6000);
        rd(5999);
        idle(3);

        // Read then reset: in-flight read is flushed; write presented during reset is ignored.
        rd(16'h0020);
        cycle(1, 0, 1, 1, 0, 1, 16'h0020, 3, 16'hDEAD, 0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("post_reset_readdata[%0d]", k), 32'(rdata_o[k]), 32'd0);
        end
        rd(16'h0020);
        rd(6000);
        idle(3);

        wr(7, 16'h00FF, 1, 1);
        rd(7);
        wr(8, 16'h5A5A, 3, 0);
        rd(8);
        rd(1);
        cycle(0, 1, 1, 1, 0, 1, 1, 3, 16'h7777, 0);
        cycle(0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        rd(1);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            op = int'($urandom_range(0, 9));
            a  = rand_addr();
            cycle(($urandom_range(0, 199) == 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) != 0) ? 1 : 0,
                  (op == 8) ? 0 : 1,
                  (op <= 3 || op == 7 || op == 8) ? 1 : 0,
                  (op >= 4 && op <= 7) ? 1 : 0,
                  a, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        idle(6);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("drain_pending[%0d]", k), 32'(sb[k].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_onchip_ram_pipelined.md
Name: nios_onchip_ram_pipelined

Overview:
- Parametrised single-port on-chip RAM with an Avalon-MM pipelined slave interface (read, write, readdatavalid).
- Next generation of the team's fixed 16-bit x 8192 on-chip memory.
- Configurable data width, depth, read latency and out-of-range handling; clock-enable stall semantics for the Nios system bus.
- Sits directly on the Nios II data/instruction master as a tightly coupled or fabric-attached memory.

Parameters:
DATA_WIDTH, 16, word width in bits; multiple of 8, range 8..128
ADDR_WIDTH, 13, word-address width
DEPTH, 8192, number of implemented words; must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2
INIT_FILE, "nios_system_onchip_ram.hex", memory initialisation file; empty string means no init

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
reset_req  in  1  reset-request; blocks acceptance and stalls the pipeline while high
clken  in  1  clock enable; pipeline advances only when clken & ~reset_req
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
address  in  ADDR_WIDTH  word address
byteenable  in  DATA_WIDTH/8  per-byte write enable
writedata  in  DATA_WIDTH  write data
readdata  out  DATA_WIDTH  read data, registered
readdatavalid  out  1  readdata valid strobe, one cycle per accepted read
range_err  out  1  sticky flag: an access hit address >= DEPTH

Behaviour:
- adv = clken & ~reset_req. No waitrequest; every request is accepted or ignored in its cycle.
- Write accepted: chipselect & write & adv. Bytes with byteenable[i]=1 update; others keep old contents.
- Read accepted: chipselect & read & ~write & adv. If read and write are both high, only the write is done and no readdatavalid is produced.
- READ_LATENCY=1:
  - Memory output is registered once.
  - readdata and readdatavalid are driven on the rising edge after acceptance.
- READ_LATENCY=2:
  - An extra output register stage is added.
  - Valid appears 2 edges after acceptance.
  - Back-to-back reads produce back-to-back valids in issue order.
- Stall: with adv=0, every pipeline stage (data and valid) holds its value. readdatavalid is forced 0 while adv=0. A held valid re-asserts on the first cycle with adv=1, so no read is lost or duplicated.
- Read-during-write: single port, so simultaneous read and write to the same port cannot occur. A read in the cycle after a write to the same address returns the new data.
- Out of range (address >= DEPTH):
  - Writes are dropped.
  - Reads complete normally with readdata = 0.
  - range_err sets on the acceptance edge and stays set until reset.
- readdata holds its last value between valids.
- Reset, checked before adv:
  - readdata = 0, readdatavalid = 0, range_err = 0.
  - All in-flight reads are flushed; no valid is issued for them after reset.
  - Memory contents are not cleared.
  - Requests in a reset cycle are ignored.
- Illegal parameters (DATA_WIDTH%8 != 0, DEPTH > 2**ADDR_WIDTH, READ_LATENCY not 1 or 2) must stop elaboration with an error.

Optional Feature:
- Macro: NIOS_ONCHIP_RAM_PARITY_EN.
- When defined:
  - Each stored byte carries an even-parity bit, written only with that byte's byteenable.
  - Parity is checked on read. Output port parity_err (1 bit) pulses alongside readdatavalid when any byte of the returned word mismatches.
  - A test-only input parity_inject (1 bit), when high during a write, inverts the stored parity of enabled bytes.
- When undefined: parity_err and parity_inject do not exist and no extra storage is inferred.

Test Plan:
- DATA_WIDTH=16, LAT=1: write 0xA55A @0x0010 with be=2'b11, read @0x0010 next cycle -> readdatavalid exactly 1 edge later, readdata=0xA55A.
- Byte enables: word @5=0x1234, write 0xFFFF with be=2'b01, read @5 -> 0x12FF.
- LAT=2: issue 4 back-to-back reads @0..3 holding 0x11,0x22,0x33,0x44 -> valids on cycles 2..5 in order; drop clken for 2 cycles mid-burst -> valids pause, none lost or duplicated.
- DEPTH=6000, ADDR_WIDTH=13: write 0xBEEF @6000, then read @6000 -> readdata=0, range_err=1 until reset; word @5999 unaffected.
- Reset one cycle after a read acceptance with LAT=2 -> no readdatavalid follows; readdata=0; previously written memory still reads back correctly.
- PARITY_EN: write 0x00FF @7 with parity_inject=1, be=2'b01 -> read @7 returns 0x00FF with parity_err=1; a clean write then read -> parity_err=0.
